mipi_capture_ctrl: RTL and testbench



---
 rtl/mipi_capture_pkg.sv | 22 ++
 rtl/mipi_line_stats.sv | 97 +++++++++
 rtl/mipi_capture_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mipi_capture_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_capture_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mipi_capture_pkg: shared state encoding and stats helpers for the capture
// sequencer.  Rev 1.0
// -----------------------------------------------------------------------------
package mipi_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int STATS_W = 16;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (&v) ? v : v + STATS_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mipi_line_stats.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mipi_line_stats: per-frame line/pixel counters and line length consistency
// check; only built with MIPI_CAPTURE_STATS_EN.  Rev 1.0
// -----------------------------------------------------------------------------
`ifdef MIPI_CAPTURE_STATS_EN
module mipi_line_stats
  import mipi_capture_pkg::*;
(
  input  logic               img_clk,
  input  logic               resetb,
  input  logic               clear,
  input  logic               active,
  input  logic               lvi,
  input  logic               dvi,
  input  logic               fvi_rise,
  output logic [STATS_W-1:0] line_cnt,
  output logic [STATS_W-1:0] last_line_px,
  output logic               line_len_err
);

  logic               lvi_prev_q, lvi_prev_d;
  logic [STATS_W-1:0] px_q, px_d;
  logic [STATS_W-1:0] line_cnt_q, line_cnt_d;
  logic [STATS_W-1:0] last_px_q, last_px_d;
  logic [STATS_W-1:0] ref_q, ref_d;
  logic               ref_valid_q, ref_valid_d;
  logic               len_err_q, len_err_d;
  logic               lvi_fall;

  assign lvi_fall = lvi_prev_q & ~lvi;

  always_comb begin
    lvi_prev_d  = lvi;
    px_d        = px_q;
    line_cnt_d  = line_cnt_q;
    last_px_d   = last_px_q;
    ref_d       = ref_q;
    ref_valid_d = ref_valid_q;
    len_err_d   = len_err_q;
    if (clear) begin
      px_d        = '0;
      line_cnt_d  = '0;
      last_px_d   = '0;
      ref_d       = '0;
      ref_valid_d = 1'b0;
      len_err_d   = 1'b0;
    end else if (fvi_rise) begin
      px_d        = '0;
      line_cnt_d  = '0;
      ref_d       = '0;
      ref_valid_d = 1'b0;
    end else if (active) begin
      if (lvi_fall) begin
        last_px_d  = px_q;
        line_cnt_d = sat_inc(line_cnt_q);
        px_d       = '0;
        // first completed line of the frame becomes the reference length
        if (!ref_valid_q) begin
          ref_d       = px_q;
          ref_valid_d = 1'b1;
        end else if (px_q != ref_q) begin
          len_err_d = 1'b1;
        end
      end else if (dvi) begin
        px_d = sat_inc(px_q);
      end
    end
  end

  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      lvi_prev_q  <= 1'b0;
      px_q        <= '0;
      line_cnt_q  <= '0;
      last_px_q   <= '0;
      ref_q       <= '0;
      ref_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      lvi_prev_q  <= lvi_prev_d;
      px_q        <= px_d;
      line_cnt_q  <= line_cnt_d;
      last_px_q   <= last_px_d;
      ref_q       <= ref_d;
      ref_valid_q <= ref_valid_d;
      len_err_q   <= len_err_d;
    end
  end

  assign line_cnt     = line_cnt_q;
  assign last_line_px = last_px_q;
  assign line_len_err = len_err_q;

endmodule
`endif
`default_nettype wire

// File: rtl/mipi_capture_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mipi_capture_ctrl: forwards only whole frames from the CSI-2 deserializer,
// counts frames, stop/watchdog abort; line stats under MIPI_CAPTURE_STATS_EN.
// Rev 1.0
// -----------------------------------------------------------------------------
module mipi_capture_ctrl
  import mipi_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int FCNT_W     = 16,
  parameter int TMO_W      = 24
) (
  input  logic                  img_clk,
  input  logic                  resetb,
  input  logic                  start,
  input  logic                  stop,
  input  logic [FCNT_W-1:0]     num_frames,
  input  logic [TMO_W-1:0]      timeout_cycles,
  output logic                  des_enable,
  input  logic                  fvi,
  input  logic                  lvi,
  input  logic                  dvi,
  input  logic [DATA_WIDTH-1:0] dati,
  output logic                  fvo,
  output logic                  lvo,
  output logic                  dvo,
  output logic [DATA_WIDTH-1:0] dato,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [FCNT_W-1:0]     frame_cnt,
  output logic [STATS_W-1:0]    line_cnt,
  output logic [STATS_W-1:0]    last_line_px,
  output logic                  line_len_err
);

  state_t                state_q, state_d;
  logic                  fvi_prev_q, fvi_prev_d;
  logic                  stop_pend_q, stop_pend_d;
  logic [FCNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [TMO_W-1:0]      wdog_q, wdog_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  des_enable_q, des_enable_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fvo_q, fvo_d, lvo_q, lvo_d, dvo_q, dvo_d;
  logic [DATA_WIDTH-1:0] dato_q, dato_d;

  logic                  fvi_rise, fvi_fall, fwd;
  logic [FCNT_W-1:0]     frame_inc;
  logic                  last_frame;
  logic [TMO_W-1:0]      wdog_next;
  logic                  wdog_hit;

  assign fvi_rise   = fvi & ~fvi_prev_q;
  assign fvi_fall   = ~fvi & fvi_prev_q;
  assign frame_inc  = frame_cnt_q + FCNT_W'(1);
  assign last_frame = (num_frames != '0) && (frame_inc == num_frames);
  assign wdog_next  = (dvi | fvi_rise | fvi_fall) ? '0 :
                      (&wdog_q) ? wdog_q : wdog_q + TMO_W'(1);
  // an edge or pixel this cycle restarts the count, so it can never fire here
  assign wdog_hit   = (timeout_cycles != '0) && !(dvi | fvi_rise | fvi_fall) &&
                      (wdog_q == timeout_cycles - TMO_W'(1));

  always_comb begin
    state_d       = state_q;
    fvi_prev_d    = fvi;
    stop_pend_d   = stop_pend_q;
    frame_cnt_d   = frame_cnt_q;
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (start) begin
          state_d       = ST_SYNC;
          stop_pend_d   = 1'b0;
          frame_cnt_d   = '0;
          timeout_err_d = 1'b0;
        end
      end
      ST_SYNC: begin
        wdog_d = wdog_next;
        if (stop) begin
          state_d = ST_DONE;
        end else if (wdog_hit) begin
          timeout_err_d = 1'b1;
          state_d       = ST_DONE;
        end else if (fvi_rise) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        wdog_d = wdog_next;
        if (stop) stop_pend_d = 1'b1;
        if (fvi_fall) begin
          if (!(&frame_cnt_q)) frame_cnt_d = frame_inc;
          if (stop_pend_q || stop || last_frame) state_d = ST_DONE;
        end else if (wdog_hit) begin
          timeout_err_d = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        wdog_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // outputs are registered against the next state so they line up with it
    fwd          = (state_d == ST_CAPTURE);
    fvo_d        = fwd & fvi;
    lvo_d        = fwd & lvi;
    dvo_d        = fwd & dvi;
    dato_d       = fwd ? dati : '0;
    des_enable_d = (state_d == ST_SYNC) || (state_d == ST_CAPTURE);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      state_q       <= ST_IDLE;
      fvi_prev_q    <= 1'b0;
      stop_pend_q   <= 1'b0;
      frame_cnt_q   <= '0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
      des_enable_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fvo_q         <= 1'b0;
      lvo_q         <= 1'b0;
      dvo_q         <= 1'b0;
      dato_q        <= '0;
    end else begin
      state_q       <= state_d;
      fvi_prev_q    <= fvi_prev_d;
      stop_pend_q   <= stop_pend_d;
      frame_cnt_q   <= frame_cnt_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
      des_enable_q  <= des_enable_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fvo_q         <= fvo_d;
      lvo_q         <= lvo_d;
      dvo_q         <= dvo_d;
      dato_q        <= dato_d;
    end
  end

  assign des_enable  = des_enable_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign fvo         = fvo_q;
  assign lvo         = lvo_q;
  assign dvo         = dvo_q;
  assign dato        = dato_q;

`ifdef MIPI_CAPTURE_STATS_EN
  logic stats_clear, stats_active, stats_rise;

  assign stats_clear  = (state_q == ST_IDLE) && start;
  assign stats_active = (state_q == ST_CAPTURE);
  assign stats_rise   = fvi_rise && ((state_q == ST_SYNC) || (state_q == ST_CAPTURE));

  mipi_line_stats u_line_stats (
    .img_clk      (img_clk),
    .resetb       (resetb),
    .clear        (stats_clear),
    .active       (stats_active),
    .lvi          (lvi),
    .dvi          (dvi),
    .fvi_rise     (stats_rise),
    .line_cnt     (line_cnt),
    .last_line_px (last_line_px),
    .line_len_err (line_len_err)
  );
`else
  assign line_cnt     = '0;
  assign last_line_px = '0;
  assign line_len_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mipi_capture_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_mipi_capture_ctrl: directed self-checking bench for the capture sequencer.
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_mipi_capture_ctrl;

`ifdef MIPI_CAPTURE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        img_clk = 1'b0;
  logic        resetb;
  logic        start, stop;
  logic [15:0] num_frames;
  logic [23:0] timeout_cycles;
  logic        des_enable;
  logic        fvi, lvi, dvi;
  logic [9:0]  dati;
  logic        fvo, lvo, dvo;
  logic [9:0]  dato;
  logic        busy, done, timeout_err;
  logic [15:0] frame_cnt, line_cnt, last_line_px;
  logic        line_len_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fwd_px, fvo_cyc, done_cnt, done_cyc, dat_bad;
  logic [9:0] pix = 10'd0;

  always #5 img_clk = ~img_clk;

  mipi_capture_ctrl #(.DATA_WIDTH(10), .FCNT_W(16), .TMO_W(24)) dut (
    .img_clk(img_clk), .resetb(resetb), .start(start), .stop(stop),
    .num_frames(num_frames), .timeout_cycles(timeout_cycles),
    .des_enable(des_enable), .fvi(fvi), .lvi(lvi), .dvi(dvi), .dati(dati),
    .fvo(fvo), .lvo(lvo), .dvo(dvo), .dato(dato), .busy(busy), .done(done),
    .timeout_err(timeout_err), .frame_cnt(frame_cnt), .line_cnt(line_cnt),
    .last_line_px(last_line_px), .line_len_err(line_len_err)
  );

  task automatic tick();
    logic [9:0] exp_dat;
    exp_dat = dati;
    @(posedge img_clk);
    #1;
    cyc++;
    if (dvo) fwd_px++;
    if (fvo) fvo_cyc++;
    if (dvo && dato !== exp_dat) dat_bad++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic clear_stats();
    fwd_px = 0; fvo_cyc = 0; done_cnt = 0; done_cyc = -1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // rise, nlines lines (8 px, last line last_px), 2-cycle line gaps, fall, 3 idle
  task automatic send_frame(input int nlines, input int last_px, input int stop_line,
                            output int fall_cyc);
    fvi = 1'b1; lvi = 1'b0; dvi = 1'b0; tick();
    for (int l = 0; l < nlines; l++) begin
      int n;
      n = (l == nlines - 1) ? last_px : 8;
      for (int p = 0; p < n; p++) begin
        lvi = 1'b1; dvi = 1'b1; dati = pix; pix = pix + 10'd1;
        stop = (l == stop_line) && (p == 0);
        tick();
      end
      stop = 1'b0; lvi = 1'b0; dvi = 1'b0;
      tick(); tick();
    end
    fvi = 1'b0; tick();
    fall_cyc = cyc;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    tick(); tick();
    tests++;
    if ({des_enable, fvo, lvo, dvo, busy, done, timeout_err, line_len_err} !== 8'h00) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {des_enable, fvo, lvo, dvo, busy, done, timeout_err, line_len_err});
    end
    tests++;
    if ({frame_cnt, line_cnt, last_line_px, 6'd0, dato} !== 64'd0) begin
      fails++;
      $display("FAIL reset_counts: frame_cnt %0d line_cnt %0d last_px %0d dato %0d expected all 0",
               frame_cnt, line_cnt, last_line_px, dato);
    end
    #2 resetb = 1'b1;
    tick();
  endtask

  task automatic test_num_frames();
    int f1, f2, f3;
    clear_stats(); dat_bad = 0;
    num_frames = 16'd2; timeout_cycles = 24'd0;
    do_start();
    tests++;
    if (des_enable !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL nf_sync_enable: des_enable %b busy %b expected 1 1", des_enable, busy);
    end
    send_frame(4, 8, -1, f1);
    send_frame(4, 8, -1, f2);
    send_frame(4, 8, -1, f3);
    tests++;
    if (fwd_px !== 64) begin
      fails++; $display("FAIL nf_fwd_px: got %0d expected 64", fwd_px);
    end
    tests++;
    if (fvo_cyc !== 82) begin
      fails++; $display("FAIL nf_fvo_cycles: got %0d expected 82", fvo_cyc);
    end
    tests++;
    if (frame_cnt !== 16'd2) begin
      fails++; $display("FAIL nf_frame_cnt: got %0d expected 2", frame_cnt);
    end
    tests++;
    if (done_cnt !== 1 || done_cyc !== f2) begin
      fails++; $display("FAIL nf_done_pulse: count %0d at %0d expected 1 at %0d", done_cnt, done_cyc, f2);
    end
    tests++;
    if (des_enable !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL nf_end_idle: des_enable %b busy %b expected 0 0", des_enable, busy);
    end
    tests++;
    if (dat_bad !== 0) begin
      fails++; $display("FAIL nf_data: %0d bad pixels expected 0", dat_bad);
    end
    tests++;
    if (line_cnt !== (STATS ? 16'd4 : 16'd0) || last_line_px !== (STATS ? 16'd8 : 16'd0) ||
        line_len_err !== 1'b0) begin
      fails++; $display("FAIL nf_stats: line_cnt %0d last_px %0d err %b expected %0d %0d 0",
                        line_cnt, last_line_px, line_len_err, STATS ? 4 : 0, STATS ? 8 : 0);
    end
  endtask

  task automatic test_mid_frame_start();
    int f;
    clear_stats();
    num_frames = 16'd1;
    fvi = 1'b1; tick();
    lvi = 1'b1; dvi = 1'b1; repeat (3) tick();
    do_start();
    repeat (3) tick();
    lvi = 1'b0; dvi = 1'b0; tick();
    fvi = 1'b0; repeat (3) tick();
    tests++;
    if (fvo_cyc !== 0 || busy !== 1'b1) begin
      fails++; $display("FAIL mid_partial_blocked: fvo cycles %0d busy %b expected 0 1", fvo_cyc, busy);
    end
    send_frame(4, 8, -1, f);
    tests++;
    if (fwd_px !== 32 || frame_cnt !== 16'd1) begin
      fails++; $display("FAIL mid_full_frame: px %0d frame_cnt %0d expected 32 1", fwd_px, frame_cnt);
    end
    tests++;
    if (done_cnt !== 1 || done_cyc !== f) begin
      fails++; $display("FAIL mid_done: count %0d at %0d expected 1 at %0d", done_cnt, done_cyc, f);
    end
  endtask

  task automatic test_stop();
    int f1, f2, f3;
    clear_stats();
    num_frames = 16'd0;
    do_start();
    send_frame(4, 8, -1, f1);
    send_frame(4, 8, -1, f2);
    send_frame(4, 8, 1, f3);
    tests++;
    if (frame_cnt !== 16'd3 || fwd_px !== 96) begin
      fails++; $display("FAIL stop_frame3: frame_cnt %0d px %0d expected 3 96", frame_cnt, fwd_px);
    end
    tests++;
    if (done_cnt !== 1 || done_cyc !== f3 || busy !== 1'b0) begin
      fails++; $display("FAIL stop_done: count %0d at %0d busy %b expected 1 at %0d busy 0",
                        done_cnt, done_cyc, busy, f3);
    end
    clear_stats();
    start = 1'b1; stop = 1'b1; tick();
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || des_enable !== 1'b1) begin
      fails++; $display("FAIL start_wins: busy %b done %b des_enable %b expected 1 0 1", busy, done, des_enable);
    end
    tick();
    stop = 1'b0;
    tests++;
    if (done !== 1'b1 || frame_cnt !== 16'd0 || des_enable !== 1'b0) begin
      fails++; $display("FAIL stop_in_sync: done %b frame_cnt %0d des_enable %b expected 1 0 0",
                        done, frame_cnt, des_enable);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || done_cnt !== 1) begin
      fails++; $display("FAIL stop_sync_idle: busy %b done count %0d expected 0 1", busy, done_cnt);
    end
  endtask

  task automatic test_watchdog();
    int early;
    clear_stats();
    early = 0;
    num_frames = 16'd0; timeout_cycles = 24'd100;
    do_start();
    fvi = 1'b1; tick();
    for (int k = 1; k < 100; k++) begin
      tick();
      if (timeout_err !== 1'b0 || fvo !== 1'b1) early++;
    end
    tests++;
    if (early !== 0) begin
      fails++; $display("FAIL wdog_early: %0d cycles with timeout_err or fvo wrong, expected 0", early);
    end
    tick();
    tests++;
    if (timeout_err !== 1'b1 || fvo !== 1'b0 || done !== 1'b1) begin
      fails++; $display("FAIL wdog_fire: timeout_err %b fvo %b done %b expected 1 0 1", timeout_err, fvo, done);
    end
    fvi = 1'b0; repeat (3) tick();
    tests++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL wdog_sticky: timeout_err %b busy %b expected 1 0", timeout_err, busy);
    end
    do_start();
    tests++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL wdog_clear: timeout_err %b busy %b expected 0 1", timeout_err, busy);
    end
    stop = 1'b1; tick(); stop = 1'b0; tick();
    timeout_cycles = 24'd0;
  endtask

  task automatic test_stats();
    int f;
    clear_stats();
    num_frames = 16'd1;
    do_start();
    send_frame(3, 7, -1, f);
    tests++;
    if (last_line_px !== (STATS ? 16'd7 : 16'd0)) begin
      fails++; $display("FAIL stats_last_px: got %0d expected %0d", last_line_px, STATS ? 7 : 0);
    end
    tests++;
    if (line_cnt !== (STATS ? 16'd3 : 16'd0)) begin
      fails++; $display("FAIL stats_line_cnt: got %0d expected %0d", line_cnt, STATS ? 3 : 0);
    end
    tests++;
    if (line_len_err !== STATS) begin
      fails++; $display("FAIL stats_len_err: got %b expected %b", line_len_err, STATS);
    end
  endtask

  task automatic test_async_reset();
    int f;
    clear_stats();
    num_frames = 16'd0;
    do_start();
    send_frame(4, 8, -1, f);
    fvi = 1'b1; tick();
    lvi = 1'b1; dvi = 1'b1; dati = 10'h155; repeat (3) tick();
    tests++;
    if (fvo !== 1'b1 || frame_cnt !== 16'd1) begin
      fails++; $display("FAIL arst_pre: fvo %b frame_cnt %0d expected 1 1", fvo, frame_cnt);
    end
    #2 resetb = 1'b0;
    #1;
    tests++;
    if ({fvo, lvo, dvo, busy, des_enable, done} !== 6'b0 || frame_cnt !== 16'd0 || dato !== 10'd0) begin
      fails++; $display("FAIL arst_outputs: flags %b frame_cnt %0d dato %0d expected 0",
                        {fvo, lvo, dvo, busy, des_enable, done}, frame_cnt, dato);
    end
    fvi = 1'b0; lvi = 1'b0; dvi = 1'b0;
    #1 resetb = 1'b1;
    repeat (3) tick();
    tests++;
    if (busy !== 1'b0 || done_cnt !== 0 || des_enable !== 1'b0) begin
      fails++; $display("FAIL arst_idle: busy %b done count %0d des_enable %b expected 0 0 0",
                        busy, done_cnt, des_enable);
    end
    clear_stats();
    num_frames = 16'd1;
    do_start();
    send_frame(4, 8, -1, f);
    tests++;
    if (fwd_px !== 32 || frame_cnt !== 16'd1 || done_cnt !== 1) begin
      fails++; $display("FAIL arst_restart: px %0d frame_cnt %0d done count %0d expected 32 1 1",
                        fwd_px, frame_cnt, done_cnt);
    end
    tests++;
    if (dat_bad !== 0) begin
      fails++; $display("FAIL data_overall: %0d bad pixels expected 0", dat_bad);
    end
  endtask

  initial begin
    resetb = 1'b0; start = 1'b0; stop = 1'b0;
    num_frames = 16'd0; timeout_cycles = 24'd0;
    fvi = 1'b0; lvi = 1'b0; dvi = 1'b0; dati = 10'd0;
    dat_bad = 0;
    clear_stats();
    test_reset();
    test_num_frames();
    test_mid_frame_start();
    test_stop();
    test_watchdog();
    test_stats();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
